// File: rtl/mem_stage_pkg.sv
// Shared widths, operation codes and types for the memory-access stage.
// A memory op is described by its byte count minus one and whether loads sign-extend.
package mem_stage_pkg;

    localparam int unsigned REGLEN     = 32;
    localparam int unsigned ADDRLEN    = 32;
    localparam int unsigned REGADDRLEN = 5;
    localparam int unsigned ALUOPLEN   = 8;
    localparam int unsigned ALUSELLEN  = 3;

    localparam logic [ALUSELLEN-1:0] EXE_NOP   = 3'b000;
    localparam logic [ALUSELLEN-1:0] EXE_LOGIC = 3'b001;
    localparam logic [ALUSELLEN-1:0] EXE_SHIFT = 3'b010;
    localparam logic [ALUSELLEN-1:0] EXE_ARITH = 3'b100;
    localparam logic [ALUSELLEN-1:0] EXE_LOAD  = 3'b110;
    localparam logic [ALUSELLEN-1:0] EXE_STORE = 3'b111;

    localparam logic [ALUOPLEN-1:0] EXE_ADD_OP = 8'h01;
    localparam logic [ALUOPLEN-1:0] EXE_OR_OP  = 8'h02;
    localparam logic [ALUOPLEN-1:0] EXE_LB_OP  = 8'h20;
    localparam logic [ALUOPLEN-1:0] EXE_LH_OP  = 8'h21;
    localparam logic [ALUOPLEN-1:0] EXE_LW_OP  = 8'h23;
    localparam logic [ALUOPLEN-1:0] EXE_LBU_OP = 8'h24;
    localparam logic [ALUOPLEN-1:0] EXE_LHU_OP = 8'h25;
    localparam logic [ALUOPLEN-1:0] EXE_SB_OP  = 8'h28;
    localparam logic [ALUOPLEN-1:0] EXE_SH_OP  = 8'h29;
    localparam logic [ALUOPLEN-1:0] EXE_SW_OP  = 8'h2B;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_ACCESS,
        MEM_DONE
    } mem_state_e;

    // Encoded as (byte count - 1) so the last-byte test is a plain compare.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd3
    } mem_size_e;

    typedef struct packed {
        mem_size_e size;
        logic      sign_ext;
    } mem_op_t;

    function automatic mem_op_t decode_mem_op(input logic [ALUOPLEN-1:0] op);
        mem_op_t d;
        d.size     = SZ_WORD;
        d.sign_ext = 1'b0;
        case (op)
            EXE_LB_OP:             begin d.size = SZ_BYTE; d.sign_ext = 1'b1; end
            EXE_LBU_OP, EXE_SB_OP: d.size = SZ_BYTE;
            EXE_LH_OP:             begin d.size = SZ_HALF; d.sign_ext = 1'b1; end
            EXE_LHU_OP, EXE_SH_OP: d.size = SZ_HALF;
            default:               d.size = SZ_WORD;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Combinational load formatter: widens 1/2/4 collected bytes to a register word.
// Kept standalone so a cache-hit path can share it.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [REGLEN-1:0] i_bytes,
    input  mem_size_e         i_size,
    input  logic              i_signed,
    output logic [REGLEN-1:0] o_word
);

    always_comb begin
        o_word = i_bytes;
        case (i_size)
            SZ_BYTE: o_word = {{24{i_signed & i_bytes[7]}}, i_bytes[7:0]};
            SZ_HALF: o_word = {{16{i_signed & i_bytes[15]}}, i_bytes[15:0]};
            default: o_word = i_bytes;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte-serial loads/stores over an 8-bit port,
// holding the upstream pipeline via stall_req while an access is in flight.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REGLEN-1:0]     rd_data_i,
    input  logic [REGADDRLEN-1:0] rd_addr_i,
    input  logic [ADDRLEN-1:0]    mem_addr_i,
    input  logic [ALUOPLEN-1:0]   aluop_i,
    input  logic [ALUSELLEN-1:0]  alusel_i,
    input  logic                  rd_enable_i,
    output logic [REGLEN-1:0]     rd_data_o,
    output logic [REGADDRLEN-1:0] rd_addr_o,
    output logic                  rd_enable_o,
    output logic                  stall_req,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDRLEN-1:0]    mem_a,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack
);

    mem_state_e            r_state;
    logic [ADDRLEN-1:0]    r_addr;
    logic [REGLEN-1:0]     r_wdata;
    logic [REGLEN-1:0]     r_rbytes;
    mem_size_e             r_size;
    logic                  r_signed;
    logic                  r_store;
    logic [1:0]            r_cnt;
    logic [REGADDRLEN-1:0] r_rd_addr;
    logic                  r_rd_enable;

    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_mem_op;
    mem_op_t               w_dec;
    logic [REGLEN-1:0]     w_ext;

    assign w_is_load  = (alusel_i == EXE_LOAD);
    assign w_is_store = (alusel_i == EXE_STORE);
    assign w_mem_op   = w_is_load | w_is_store;
    assign w_dec      = decode_mem_op(aluop_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= MEM_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rbytes    <= '0;
            r_size      <= SZ_BYTE;
            r_signed    <= 1'b0;
            r_store     <= 1'b0;
            r_cnt       <= '0;
            r_rd_addr   <= '0;
            r_rd_enable <= 1'b0;
        end else begin
            case (r_state)
                MEM_IDLE: begin
                    if (w_mem_op) begin
                        r_state     <= MEM_ACCESS;
                        r_addr      <= w_is_store ? mem_addr_i : rd_data_i;
                        r_wdata     <= w_is_store ? rd_data_i : '0;
                        r_rbytes    <= '0;
                        r_size      <= w_dec.size;
                        r_signed    <= w_dec.sign_ext;
                        r_store     <= w_is_store;
                        r_cnt       <= '0;
                        r_rd_addr   <= rd_addr_i;
                        r_rd_enable <= w_is_load & rd_enable_i;
                    end
                end
                MEM_ACCESS: begin
                    if (mem_ack) begin
                        if (!r_store) begin
                            r_rbytes[{r_cnt, 3'b000} +: 8] <= mem_rdata;
                        end
                        if (r_cnt == r_size) begin
                            r_state <= MEM_DONE;
                        end else begin
                            // Store data shifts down so byte k is always in the low lane.
                            r_cnt   <= r_cnt + 2'd1;
                            r_addr  <= r_addr + 32'd1;
                            r_wdata <= r_wdata >> 8;
                        end
                    end
                end
                MEM_DONE: r_state <= MEM_IDLE;
                default:  r_state <= MEM_IDLE;
            endcase
        end
    end

    load_extend u_load_extend (
        .i_bytes  (r_rbytes),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_word   (w_ext)
    );

    // Reset also masks the combinational pass-through so every output reads 0 while rst is low.
    always_comb begin
        rd_data_o   = '0;
        rd_addr_o   = '0;
        rd_enable_o = 1'b0;
        stall_req   = 1'b0;
        if (rst) begin
            case (r_state)
                MEM_IDLE: begin
                    if (w_mem_op) begin
                        stall_req = 1'b1;
                    end else begin
                        rd_data_o   = rd_data_i;
                        rd_addr_o   = rd_addr_i;
                        rd_enable_o = rd_enable_i;
                    end
                end
                MEM_ACCESS: stall_req = 1'b1;
                MEM_DONE: begin
                    rd_data_o   = r_store ? '0 : w_ext;
                    rd_addr_o   = r_rd_addr;
                    rd_enable_o = r_rd_enable;
                end
                default: stall_req = 1'b0;
            endcase
        end
    end

    assign mem_req   = (r_state == MEM_ACCESS);
    assign mem_we    = r_store;
    assign mem_a     = r_addr;
    assign mem_wdata = r_wdata[7:0];

endmodule
